// File: rtl/quantser_mc.sv
// quantser_mc: N-lane quantizer feeding a double-buffered, lockstep bit-serial output.
// Each accepted word is reduced per lane to a (bdout+1)-bit field and shifted out MSB-first.
module quantser_mc #(
  parameter int N        = 4,
  parameter int BDIN     = 32,
  parameter int BDOUTMAX = 32,
  localparam int MW      = $clog2(BDIN),
  localparam int BW      = $clog2(BDOUTMAX)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [MW-1:0]     msbidx,
  input  logic [BW-1:0]     bdout,
  input  logic              rnd,
  input  logic              sat,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*BDIN-1:0] din,
  output logic              out_valid,
  output logic              out_last,
  output logic [N-1:0]      dout
);
  localparam int AW = (BDIN > BDOUTMAX) ? BDIN : BDOUTMAX;
  localparam int SW = ((MW > BW) ? MW : BW) + 2;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  // Lane-independent field geometry, derived once from msbidx/bdout.
  logic signed [SW-1:0] lsb_pos;
  logic [SW-1:0]        lsb_abs;
  logic                 lsb_neg;
  logic                 round_en;
  logic [MW-1:0]        rb_idx;
  logic [BW-1:0]        pad_amt;
  logic [BDOUTMAX-1:0]  field_mask;
  logic [BDOUTMAX-1:0]  max_pos;
  logic [BDOUTMAX-1:0]  min_neg;

  always_comb begin
    lsb_pos    = SW'(msbidx) - SW'(bdout);
    lsb_neg    = lsb_pos[SW-1];
    lsb_abs    = lsb_neg ? -lsb_pos : lsb_pos;
    round_en   = rnd && !lsb_neg && (lsb_pos != '0);
    rb_idx     = MW'(lsb_abs - SW'(1));
    pad_amt    = BW'(BDOUTMAX - 1) - bdout;
    field_mask = {BDOUTMAX{1'b1}} >> pad_amt;
    max_pos    = field_mask >> 1;
    min_neg    = field_mask & ~max_pos;
  end

  // Quantized lanes, left-aligned so the field MSB sits at bit BDOUTMAX-1.
  logic [BDOUTMAX-1:0] quant_lane [N];
  logic [BDOUTMAX-1:0] shift_q [N];
  logic [BDOUTMAX-1:0] shift_d [N];
  logic [BDOUTMAX-1:0] hold_q [N];
  logic [BDOUTMAX-1:0] hold_d [N];
  logic [BW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       hold_cnt_q, hold_cnt_d;
  logic                hold_full_q, hold_full_d;
  state_t              state_q, state_d;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [BDIN-1:0]     lane;
    logic [AW-1:0]       aligned;
    logic [BDOUTMAX-1:0] field;
    logic [BDOUTMAX-1:0] wrapped;
    logic [BDOUTMAX-1:0] clamped;
    logic [BDOUTMAX-1:0] q_aligned;
    logic                rbit;
    logic                upper_eq;
    logic                ovf;

    assign lane = din[gi*BDIN +: BDIN];

    always_comb begin
      aligned  = lsb_neg ? (AW'(lane) << lsb_abs) : (AW'(lane) >> lsb_abs);
      field    = aligned[BDOUTMAX-1:0] & field_mask;
      rbit     = round_en & lane[rb_idx];
      wrapped  = (field + BDOUTMAX'(rbit)) & field_mask;
      // Bits from msbidx upward must all match the sign for the value to fit.
      upper_eq = ((lane ^ {BDIN{lane[BDIN-1]}}) >> msbidx) == '0;
      ovf      = sat & (~upper_eq | (rbit & (field == max_pos)));
      clamped  = lane[BDIN-1] ? min_neg : max_pos;
      q_aligned = (ovf ? clamped : wrapped) << pad_amt;
    end

    assign quant_lane[gi] = q_aligned;
    assign dout[gi]       = (state_q == ST_SHIFT) & shift_q[gi][BDOUTMAX-1];
  end

  logic accept;
  logic reload;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_cnt_d  = hold_cnt_q;
    hold_full_d = hold_full_q;
    accept      = in_valid && !hold_full_q;
    reload      = (state_q == ST_IDLE) || (cnt_q == '0);

    if (reload) begin
      // The held word always wins; a direct load only happens with the hold empty.
      if (hold_full_q) begin
        shift_d     = hold_q;
        cnt_d       = hold_cnt_q;
        state_d     = ST_SHIFT;
        hold_full_d = 1'b0;
      end else if (accept) begin
        shift_d = quant_lane;
        cnt_d   = bdout;
        state_d = ST_SHIFT;
      end else begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        shift_d[i] = shift_q[i] << 1;
      end
      cnt_d = cnt_q - BW'(1);
      if (accept) begin
        hold_d      = quant_lane;
        hold_cnt_d  = bdout;
        hold_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hold_cnt_q  <= '0;
      hold_full_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        shift_q[i] <= '0;
        hold_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
    end
  end

  assign in_ready  = ~hold_full_q;
  assign out_valid = (state_q == ST_SHIFT);
  assign out_last  = (state_q == ST_SHIFT) && (cnt_q == '0);

endmodule

// File: tb/tb_quantser_mc.sv
// Bench for quantser_mc: directed datasheet cases plus random words, scored bit-by-bit
// against an integer-arithmetic model of the quantizer through an expected-bit queue.
`timescale 1ns/1ps
module tb_quantser_mc;
  localparam int N        = 4;
  localparam int BDIN     = 32;
  localparam int BDOUTMAX = 32;

  logic              clk = 1'b0;
  logic              clr = 1'b1;
  logic [4:0]        msbidx = '0;
  logic [4:0]        bdout = '0;
  logic              rnd = 1'b0;
  logic              sat = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N*BDIN-1:0] din = '0;
  logic              out_valid;
  logic              out_last;
  logic [N-1:0]      dout;

  quantser_mc #(.N(N), .BDIN(BDIN), .BDOUTMAX(BDOUTMAX)) dut (
    .clk(clk), .clr(clr), .msbidx(msbidx), .bdout(bdout), .rnd(rnd), .sat(sat),
    .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_last(out_last), .dout(dout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] bits;
    logic         last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   run_cur = 0;
  int   last_run = 0;
  int   waits = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Reference: signed value scaled by 2^-L with floor, plus round bit, then clamp or wrap.
  function automatic longint quant(input logic [31:0] x, input int m, input int b,
                                   input bit r, input bit s);
    longint v, q, hi, lo;
    int     lpos, p;
    v    = longint'($signed(x));
    p    = b + 1;
    lpos = m - b;
    if (lpos >= 0) q = v >>> lpos;
    else           q = v * (longint'(1) << (-lpos));
    if (r && lpos >= 1) q = q + ((v >>> (lpos - 1)) & 1);
    hi = (longint'(1) << (p - 1)) - 1;
    lo = -(longint'(1) << (p - 1));
    if (s) begin
      if (q > hi) q = hi;
      if (q < lo) q = lo;
    end
    return q & ((longint'(1) << p) - 1);
  endfunction

  task automatic push_word(input logic [N*BDIN-1:0] d, input int m, input int b,
                           input bit r, input bit s);
    logic [63:0] qv [N];
    exp_t        e;
    for (int i = 0; i < N; i++) qv[i] = 64'(quant(d[i*BDIN +: BDIN], m, b, r, s));
    for (int k = b; k >= 0; k--) begin
      for (int i = 0; i < N; i++) e.bits[i] = qv[i][k];
      e.last = (k == 0);
      sb.push_back(e);
    end
  endtask

  function automatic logic [N*BDIN-1:0] rand_word();
    logic [N*BDIN-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 3))
        0:       w[i*BDIN +: BDIN] = $urandom();
        1:       w[i*BDIN +: BDIN] = 32'($urandom_range(0, 1023));
        2:       w[i*BDIN +: BDIN] = -32'($urandom_range(0, 1023));
        default: w[i*BDIN +: BDIN] = $urandom() >> $urandom_range(0, 31);
      endcase
    end
    return w;
  endfunction

  // Presents one word and returns at accept edge + 1 time unit.
  task automatic send(input logic [N*BDIN-1:0] d, input int m, input int b,
                      input bit r, input bit s);
    int g;
    din      = d;
    msbidx   = 5'(m);
    bdout    = 5'(b);
    rnd      = r;
    sat      = s;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 200) begin
      @(posedge clk);
      #1;
      g++;
      waits++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", g);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    push_word(d, m, b, r, s);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while ((out_valid || sb.size() != 0) && g < 400);
    n_checks++;
    if (out_valid || sb.size() != 0)
      $display("FAIL drain_timeout: out_valid=%0b pending_bits=%0d", out_valid, sb.size());
    else n_pass++;
    #1;
  endtask

  // Monitor: every valid cycle pops one expected bit-column.
  always @(negedge clk) begin
    exp_t e;
    if (clr) begin
      run_cur = 0;
    end else if (out_valid) begin
      run_cur++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_underflow: out_valid=1 dout=0x%0h with no bit expected", dout);
      end else begin
        e = sb.pop_front();
        check("dout", 64'(dout), 64'(e.bits));
        check("out_last", 64'(out_last), 64'(e.last));
      end
    end else begin
      if (run_cur != 0) last_run = run_cur;
      run_cur = 0;
      check("idle_outputs", 64'({out_last, dout}), 64'(0));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N*BDIN-1:0] w;
    int m, b;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_dout", 64'(dout), 64'(0));
    clr = 1'b0;
    @(negedge clk);

    // Basic field extraction and first-bit latency.
    w = rand_word();
    w[31:0] = 32'h000000B4;
    send(w, 7, 3, 1'b0, 1'b0);
    check("first_valid", 64'(out_valid), 64'(1));
    check("first_msb_lane0", 64'(dout[0]), 64'(1));
    check("first_not_last", 64'(out_last), 64'(0));
    wait_idle();

    // Rounding, wrap and saturating round.
    w = rand_word(); w[31:0] = 32'h0000001C; send(w, 4, 2, 1'b1, 1'b0);
    w = rand_word(); w[31:0] = 32'h0000001E; send(w, 4, 2, 1'b1, 1'b0);
    w = rand_word(); w[31:0] = 32'h0000001E; send(w, 4, 2, 1'b1, 1'b1);
    wait_idle();

    // Saturation both directions.
    w = rand_word(); w[31:0] = 32'hFFFFF000; send(w, 7, 7, 1'b0, 1'b1);
    w = rand_word(); w[31:0] = 32'h00000100; send(w, 7, 7, 1'b0, 1'b1);
    wait_idle();

    // Back-to-back P=3 words: 9 contiguous bits, with a stall on the third.
    waits = 0;
    for (int i = 0; i < 3; i++) send(rand_word(), 9, 2, 1'b0, 1'b0);
    wait_idle();
    check("b2b_run_len", 64'(last_run), 64'(9));
    check("b2b_stalled", 64'(waits > 0), 64'(1));

    // Single-bit words stream without gaps.
    for (int i = 0; i < 5; i++) send(rand_word(), $urandom_range(0, 31), 0, 1'b0, 1'b0);
    wait_idle();
    check("p1_run_len", 64'(last_run), 64'(5));

    // Field reaching below bit 0.
    send(rand_word(), 1, 3, 1'b1, 1'b0);
    send(rand_word(), 1, 3, 1'b0, 1'b1);
    wait_idle();

    // Clear during bit 2 of an 8-bit word with the hold stage full.
    send(rand_word(), 15, 7, 1'b0, 1'b0);
    send(rand_word(), 20, 7, 1'b0, 1'b0);
    check("clr_hold_full", 64'(in_ready), 64'(0));
    #2;
    clr = 1'b1;
    sb.delete();
    #1;
    check("clr_out_valid", 64'(out_valid), 64'(0));
    check("clr_in_ready", 64'(in_ready), 64'(1));
    check("clr_out_last", 64'(out_last), 64'(0));
    @(posedge clk);
    #2;
    clr = 1'b0;
    repeat (3) @(negedge clk);
    check("post_clr_quiet", 64'(out_valid), 64'(0));
    w = rand_word(); w[31:0] = 32'h000000B4;
    send(w, 7, 7, 1'b0, 1'b0);
    wait_idle();

    // Random words with random gaps and settings.
    for (int n = 0; n < 80; n++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      m = $urandom_range(0, 31);
      b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
      send(rand_word(), m, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    check("final_in_ready", 64'(in_ready), 64'(1));
    check("final_sb_empty", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
